// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores over the req/addr_ok/data_ok data-SRAM
// handshake, steers byte/half lanes and hands a registered result to write-back.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        memop_i,
    input  logic [31:0]       ex_wdata_i,
    input  logic [31:0]       store_data_i,
    input  logic              wreg_i,
    input  logic [4:0]        waddr_i,
    output logic              stall_o,
    output logic              data_sram_req_o,
    output logic              data_sram_wr_o,
    output logic [1:0]        data_sram_size_o,
    output logic [ADDR_W-1:0] data_sram_addr_o,
    output logic [31:0]       data_sram_wdata_o,
    output logic [3:0]        data_sram_wstrb_o,
    input  logic              data_sram_addr_ok_i,
    input  logic              data_sram_data_ok_i,
    input  logic [31:0]       data_sram_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_waddr_o,
    output logic [31:0]       wb_wdata_o,
    output logic              addr_err_o,
    output logic [31:0]       badvaddr_o
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd2;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op_size(op))
            2'd1:    return a[0];
            2'd2:    return a != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] sd);
        case (op)
            OP_SB:   return {4{sd[7:0]}};
            OP_SH:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [3:0] op, input logic [1:0] o);
        case (op)
            OP_SB:   return 4'b0001 << o;
            OP_SH:   return o[1] ? 4'b1100 : 4'b0011;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] o,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*o +: 8];
        h = rd[16*o[1] +: 16];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  op_r;
    logic [1:0]  off_r;
    logic        wreg_r;
    logic [4:0]  waddr_r;
    logic        mem_op_s, misalign_s, done_s;
    logic [31:0] load_s;

    assign mem_op_s   = is_mem(memop_i);
    assign misalign_s = misaligned(memop_i, ex_wdata_i[1:0]);
    assign done_s     = ((state_r == ST_REQ) && data_sram_addr_ok_i && data_sram_data_ok_i) ||
                        ((state_r == ST_WAIT) && data_sram_data_ok_i);
    assign load_s     = load_extract(op_r, off_r, data_sram_rdata_i);
    assign stall_o    = (state_r != ST_IDLE);

    // Next-state logic for the handshake FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i && mem_op_s && !misalign_s) state_nx_s = ST_REQ;
                else                                    state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (data_sram_addr_ok_i) state_nx_s = data_sram_data_ok_i ? ST_IDLE : ST_WAIT;
                else                     state_nx_s = ST_REQ;
            end
            ST_WAIT: begin
                if (data_sram_data_ok_i) state_nx_s = ST_IDLE;
                else                     state_nx_s = ST_WAIT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, captured instruction, SRAM request and write-back registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r           <= ST_IDLE;
            op_r              <= 4'd0;
            off_r             <= 2'd0;
            wreg_r            <= 1'b0;
            waddr_r           <= 5'd0;
            data_sram_req_o   <= 1'b0;
            data_sram_wr_o    <= 1'b0;
            data_sram_size_o  <= 2'd0;
            data_sram_addr_o  <= '0;
            data_sram_wdata_o <= 32'd0;
            data_sram_wstrb_o <= 4'd0;
            wb_valid_o        <= 1'b0;
            wb_we_o           <= 1'b0;
            wb_waddr_o        <= 5'd0;
            wb_wdata_o        <= 32'd0;
            addr_err_o        <= 1'b0;
            badvaddr_o        <= 32'd0;
        end else begin
            state_r    <= state_nx_s;
            wb_valid_o <= 1'b0;
            addr_err_o <= 1'b0;
            if ((state_r == ST_IDLE) && valid_i) begin
                if (!mem_op_s) begin
                    wb_valid_o <= 1'b1;
                    wb_we_o    <= wreg_i;
                    wb_waddr_o <= waddr_i;
                    wb_wdata_o <= ex_wdata_i;
                end else if (misalign_s) begin
                    addr_err_o <= 1'b1;
                    badvaddr_o <= ex_wdata_i;
                end else begin
                    op_r              <= memop_i;
                    off_r             <= ex_wdata_i[1:0];
                    wreg_r            <= wreg_i;
                    waddr_r           <= waddr_i;
                    data_sram_req_o   <= 1'b1;
                    data_sram_wr_o    <= is_store(memop_i);
                    data_sram_size_o  <= op_size(memop_i);
                    data_sram_addr_o  <= ex_wdata_i[ADDR_W-1:0];
                    data_sram_wdata_o <= store_wdata(memop_i, store_data_i);
                    data_sram_wstrb_o <= store_wstrb(memop_i, ex_wdata_i[1:0]);
                end
            end
            if ((state_r == ST_REQ) && data_sram_addr_ok_i) data_sram_req_o <= 1'b0;
            // Stores complete with a non-writing write-back pulse; wdata keeps its last value.
            if (done_s) begin
                wb_valid_o <= 1'b1;
                wb_waddr_o <= waddr_r;
                if (is_store(op_r)) begin
                    wb_we_o <= 1'b0;
                end else begin
                    wb_we_o    <= wreg_r;
                    wb_wdata_o <= load_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: fixed-cycle stimulus with hand-computed expectations.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  memop_i;
    logic [31:0] ex_wdata_i, store_data_i;
    logic        wreg_i;
    logic [4:0]  waddr_i;
    logic        stall_o, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        addr_err;
    logic [31:0] badvaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .memop_i(memop_i),
        .ex_wdata_i(ex_wdata_i), .store_data_i(store_data_i),
        .wreg_i(wreg_i), .waddr_i(waddr_i), .stall_o(stall_o),
        .data_sram_req_o(req), .data_sram_wr_o(wr), .data_sram_size_o(size),
        .data_sram_addr_o(addr), .data_sram_wdata_o(wdata), .data_sram_wstrb_o(wstrb),
        .data_sram_addr_ok_i(addr_ok), .data_sram_data_ok_i(data_ok),
        .data_sram_rdata_i(rdata), .wb_valid_o(wb_valid), .wb_we_o(wb_we),
        .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata), .addr_err_o(addr_err),
        .badvaddr_o(badvaddr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single cycle; afterwards valid_i is low again.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic wr_en, input logic [4:0] wa);
        valid_i = 1'b1; memop_i = op; ex_wdata_i = a; store_data_i = sd;
        wreg_i = wr_en; waddr_i = wa;
        step();
        valid_i = 1'b0; memop_i = 4'd0;
    endtask

    // Respond with addr_ok and data_ok in the same cycle.
    task automatic respond_fast(input logic [31:0] rd);
        addr_ok = 1'b1; data_ok = 1'b1; rdata = rd;
        step();
        addr_ok = 1'b0; data_ok = 1'b0;
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b0; memop_i = 4'd0; ex_wdata_i = 32'd0;
        store_data_i = 32'd0; wreg_i = 1'b0; waddr_i = 5'd0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
        step(); step();
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_badvaddr", badvaddr, 32'd0);
        rst = 1'b1;
        step();

        // NONE op passes the EX value straight through in one cycle.
        issue(4'd0, 32'h0000_0003, 32'd0, 1'b1, 5'd5);
        chk("none_valid", {31'd0, wb_valid}, 32'd1);
        chk("none_we", {31'd0, wb_we}, 32'd1);
        chk("none_waddr", {27'd0, wb_waddr}, 32'd5);
        chk("none_wdata", wb_wdata, 32'h0000_0003);
        chk("none_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("none_pulse", {31'd0, wb_valid}, 32'd0);

        // memop 9 behaves as NONE.
        issue(4'd9, 32'h0000_0055, 32'd0, 1'b0, 5'd9);
        chk("op9_valid", {31'd0, wb_valid}, 32'd1);
        chk("op9_we", {31'd0, wb_we}, 32'd0);
        chk("op9_wdata", wb_wdata, 32'h0000_0055);

        // LB 0x1003, addr_ok and data_ok each one cycle late; stray data_ok before addr_ok.
        issue(4'd1, 32'h0000_1003, 32'd0, 1'b1, 5'd7);
        chk("lb_req", {31'd0, req}, 32'd1);
        chk("lb_wr", {31'd0, wr}, 32'd0);
        chk("lb_size", {30'd0, size}, 32'd0);
        chk("lb_wstrb", {28'd0, wstrb}, 32'd0);
        chk("lb_addr", addr, 32'h0000_1003);
        chk("lb_stall", {31'd0, stall_o}, 32'd1);
        data_ok = 1'b1; rdata = 32'h1111_1111;
        step();
        data_ok = 1'b0;
        chk("lb_ignore_dok", {31'd0, wb_valid}, 32'd0);
        chk("lb_req_held", {31'd0, req}, 32'd1);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        chk("lb_req_drop", {31'd0, req}, 32'd0);
        chk("lb_wait_stall", {31'd0, stall_o}, 32'd1);
        step();
        chk("lb_wait_novalid", {31'd0, wb_valid}, 32'd0);
        data_ok = 1'b1; rdata = 32'h80FF_1234;
        step();
        data_ok = 1'b0;
        chk("lb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_we", {31'd0, wb_we}, 32'd1);
        chk("lb_waddr", {27'd0, wb_waddr}, 32'd7);
        chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);
        chk("lb_stall_end", {31'd0, stall_o}, 32'd0);

        // LHU / LH of the upper half.
        issue(4'd4, 32'h0000_2002, 32'd0, 1'b1, 5'd3);
        chk("lhu_size", {30'd0, size}, 32'd1);
        respond_fast(32'hBEEF_0000);
        chk("lhu_valid", {31'd0, wb_valid}, 32'd1);
        chk("lhu_wdata", wb_wdata, 32'h0000_BEEF);
        issue(4'd3, 32'h0000_2002, 32'd0, 1'b1, 5'd3);
        respond_fast(32'hBEEF_0000);
        chk("lh_wdata", wb_wdata, 32'hFFFF_BEEF);

        // SB to lane 1.
        issue(4'd6, 32'h0000_1001, 32'h0000_00AB, 1'b1, 5'd4);
        chk("sb_wdata", wdata, 32'hABAB_ABAB);
        chk("sb_wstrb", {28'd0, wstrb}, 32'h0000_0002);
        chk("sb_wr", {31'd0, wr}, 32'd1);
        respond_fast(32'd0);
        chk("sb_valid", {31'd0, wb_valid}, 32'd1);
        chk("sb_we", {31'd0, wb_we}, 32'd0);

        // SH to the upper half.
        issue(4'd7, 32'h0000_1002, 32'h1234_5678, 1'b0, 5'd0);
        chk("sh_wdata", wdata, 32'h5678_5678);
        chk("sh_wstrb", {28'd0, wstrb}, 32'h0000_000C);
        chk("sh_size", {30'd0, size}, 32'd1);
        respond_fast(32'd0);

        // Misaligned LW raises an address error and issues no request.
        issue(4'd5, 32'h0000_3002, 32'd0, 1'b1, 5'd8);
        chk("lw_err", {31'd0, addr_err}, 32'd1);
        chk("lw_badvaddr", badvaddr, 32'h0000_3002);
        chk("lw_noreq", {31'd0, req}, 32'd0);
        chk("lw_novalid", {31'd0, wb_valid}, 32'd0);
        chk("lw_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("lw_err_pulse", {31'd0, addr_err}, 32'd0);
        chk("lw_noreq2", {31'd0, req}, 32'd0);
        chk("lw_badv_hold", badvaddr, 32'h0000_3002);

        // SW with addr_ok held off three cycles: request stays stable.
        issue(4'd8, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            chk("sw_req_hold", {31'd0, req}, 32'd1);
            chk("sw_addr_hold", addr, 32'h0000_4000);
            chk("sw_wdata_hold", wdata, 32'hDEAD_BEEF);
            chk("sw_wstrb_hold", {28'd0, wstrb}, 32'h0000_000F);
            chk("sw_stall_hold", {31'd0, stall_o}, 32'd1);
            step();
        end
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        chk("sw_wait", {31'd0, stall_o}, 32'd1);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        chk("sw_valid", {31'd0, wb_valid}, 32'd1);
        chk("sw_we", {31'd0, wb_we}, 32'd0);

        // Reset while waiting for data abandons the load; late data_ok ignored.
        issue(4'd5, 32'h0000_5000, 32'd0, 1'b1, 5'd6);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        chk("rw_wait_stall", {31'd0, stall_o}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rw_idle", {31'd0, stall_o}, 32'd0);
        chk("rw_req", {31'd0, req}, 32'd0);
        data_ok = 1'b1; rdata = 32'h1234_5678;
        step();
        data_ok = 1'b0;
        chk("rw_late_dok", {31'd0, wb_valid}, 32'd0);
        chk("rw_wdata", wb_wdata, 32'd0);
        step();
        chk("rw_late_dok2", {31'd0, wb_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
